// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - Operand adder/accumulator with a FIFO result buffer.
// Optional macro ADDER_PIPE_SAT_EN: accumulate results saturate instead of wrapping.
module adder_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       acc_mode,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             y,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int RW = WIDTH + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [RW:0]   RES_MAX = {1'b0, {RW{1'b1}}};

    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [RW-1:0] acc_q, acc_d;

    logic          accept;
    logic          pop;
    logic [RW-1:0] acc_base;
    logic [RW:0]   sum_wide;
    logic [RW-1:0] plain_sum;
    logic [RW-1:0] acc_res;
    logic [RW-1:0] res;

    always_comb begin
        in_ready  = (count_q != FULL);
        out_valid = (count_q != '0);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;

        acc_base  = acc_clr ? '0 : acc_q;
        sum_wide  = {1'b0, acc_base} + {2'b0, a} + {2'b0, b};
        plain_sum = {1'b0, a} + {1'b0, b};
`ifdef ADDER_PIPE_SAT_EN
        acc_res   = (sum_wide > RES_MAX) ? RES_MAX[RW-1:0] : sum_wide[RW-1:0];
`else
        acc_res   = sum_wide[RW-1:0];
`endif
        res       = acc_mode ? acc_res : plain_sum;

        // An accumulate accept already folds the clear into acc_base.
        acc_d = acc_q;
        if (accept && acc_mode) begin
            acc_d = acc_res;
        end else if (acc_clr) begin
            acc_d = '0;
        end

        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        count = count_q;
        y     = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Storage is left uncleared on reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= res;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - Directed self-checking bench for adder_pipe (WIDTH=4, DEPTH=4).
module tb_adder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       acc_mode;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] y;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    adder_pipe #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic m, input logic clr, input logic rdy);
        in_valid  = v;
        a         = av;
        b         = bv;
        acc_mode  = m;
        acc_clr   = clr;
        out_ready = rdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int vec_a [5] = '{1, 5, 7, 2, 9};
    int vec_b [5] = '{3, 6, 8, 2, 9};
    int drain_exp [4] = '{4, 11, 15, 4};
    int sat_exp;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_y", 32'(y), 0);
        check("reset_count", 32'(count), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        step();
        step();
        #2 rst = 1'b0;

        // First accept right after reset release
        drive(1, 1, 3, 0, 0, 0);
        step();
        check("first_out_valid", 32'(out_valid), 1);
        check("first_y", 32'(y), 4);
        check("first_count", 32'(count), 1);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("first_drain_count", 32'(count), 0);
        step();
        check("empty_pop_no_underflow", 32'(count), 0);

        // Fill to full with a fifth offer rejected
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'(vec_a[i]), 4'(vec_b[i]), 0, 0, 0);
            check($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 1 : 0);
            step();
        end
        check("full_count", 32'(count), 4);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_y_%0d", i), 32'(y), 32'(drain_exp[i]));
            step();
        end
        check("drained_out_valid", 32'(out_valid), 0);
        check("drained_y_zero", 32'(y), 0);

        // Accumulate with wrap or saturation
        drive(0, 0, 0, 0, 1, 1);
        step();
        drive(1, 7, 8, 1, 0, 1);
        step();
        check("acc_first_y", 32'(y), 15);
`ifdef ADDER_PIPE_SAT_EN
        sat_exp = 31;
`else
        sat_exp = 13;
`endif
        drive(1, 15, 15, 1, 0, 1);
        step();
        check("acc_overflow_y", 32'(y), 32'(sat_exp));
        check("acc_pop_push_count", 32'(count), 1);

        // acc=20, then clear folded into an accumulate accept
        drive(1, 10, 10, 1, 1, 1);
        step();
        check("acc_twenty_y", 32'(y), 20);
        drive(1, 2, 3, 1, 1, 1);
        step();
        check("acc_clr_accept_y", 32'(y), 5);
        drive(1, 0, 0, 1, 0, 1);
        step();
        check("acc_holds_five", 32'(y), 5);
        drive(1, 1, 1, 0, 0, 1);
        step();
        check("plain_in_acc_run", 32'(y), 2);
        drive(1, 1, 0, 1, 0, 1);
        step();
        check("plain_keeps_acc", 32'(y), 6);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("acc_drain_count", 32'(count), 0);

        // Simultaneous accept and pop at count=2
        drive(1, 1, 1, 0, 0, 0);
        step();
        drive(1, 2, 2, 0, 0, 0);
        step();
        check("sim_pre_count", 32'(count), 2);
        check("sim_pre_y", 32'(y), 2);
        drive(1, 3, 3, 0, 0, 1);
        step();
        check("sim_count", 32'(count), 2);
        check("sim_y", 32'(y), 4);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("sim_tail_y", 32'(y), 6);
        step();
        check("sim_empty_count", 32'(count), 0);

        // Asynchronous reset at count=3
        drive(1, 1, 2, 0, 0, 0);
        step();
        drive(1, 2, 3, 0, 0, 0);
        step();
        drive(1, 3, 4, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("pre_rst_count", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_count", 32'(count), 0);
        check("async_rst_y", 32'(y), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        #1 rst = 1'b0;
        drive(1, 1, 1, 0, 0, 0);
        step();
        check("post_rst_y", 32'(y), 2);
        check("post_rst_count", 32'(count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; result width is WIDTH+1.
REQ-002 Parameter DEPTH, default 4: result-buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b presented.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 acc_mode  input  1  0 = plain add, 1 = accumulate; sampled with each accepted pair.
REQ-010 acc_clr  input  1  clear accumulator; sampled every cycle.
REQ-011 out_valid  output  1  buffer head holds a result.
REQ-012 out_ready  input  1  consumer takes head result this cycle.
REQ-013 y  output  WIDTH+1  buffer head result.
REQ-014 count  output  $clog2(DEPTH+1)  results currently buffered.

Function
REQ-015 Accept = in_valid && in_ready; pop = out_valid && out_ready; both are evaluated in the same cycle.
REQ-016 in_ready SHALL be (count < DEPTH), derived from registered count only; no combinational path from out_ready.
REQ-017 out_valid SHALL be (count != 0); y SHALL show the oldest buffered result, or 0 when count == 0.
REQ-018 Plain add (acc_mode=0): result = zero-extended a + zero-extended b, exact in WIDTH+1 bits; accumulator unchanged.
REQ-019 Accumulate (acc_mode=1): result = acc_base + a + b, where acc_base = 0 if acc_clr is high that cycle, otherwise acc; acc <= result at the same edge.
REQ-020 Accumulate overflow SHALL wrap modulo 2^(WIDTH+1) unless REQ-031 applies.
REQ-021 acc_clr high without an accumulate accept SHALL set acc to 0 at the edge.
REQ-022 Latency: a pair accepted at edge N SHALL be visible on y with out_valid=1 from edge N, if the buffer was empty; otherwise it appears after all older results.
REQ-023 Order SHALL be strict FIFO; write and read pointers wrap modulo DEPTH.
REQ-024 Simultaneous accept and pop: count unchanged, head advances, new result enters at the tail.
REQ-025 Full (count == DEPTH): in_ready=0, in_valid ignored, no state change from inputs a/b/acc_mode.
REQ-026 Empty: out_ready ignored; count SHALL never underflow.
REQ-027 in_valid low: a, b and acc_mode ignored; acc is affected only by acc_clr.

Reset
REQ-028 On rst high, immediately and independent of clk: count=0, pointers=0, acc=0, out_valid=0, y=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard all buffered results; buffer storage need not be cleared.
REQ-030 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro ADDER_PIPE_SAT_EN defined: accumulate results saturate at 2^(WIDTH+1)-1, and acc holds the saturated value. Macro undefined: accumulate results wrap per REQ-020. Plain add is identical in both builds.

Verification (WIDTH=4, DEPTH=4)
REQ-032 Reset, accept a=1,b=3,acc_mode=0 -> after edge, out_valid=1, y=4, count=1.
REQ-033 out_ready=0; offer pairs (1,3),(5,6),(7,8),(2,2),(9,9) on consecutive cycles -> first four accepted, in_ready=0 at count=4, fifth not accepted; drain yields 4,11,15,4 then out_valid=0.
REQ-034 Accumulate after acc_clr: (7,8) -> y=15; then (15,15) -> y=13 (wrap) or y=31 with ADDER_PIPE_SAT_EN.
REQ-035 acc=20, then acc_clr=1 with accumulate accept (2,3) -> y=5, acc=5.
REQ-036 At count=2, accept and pop in the same cycle -> count stays 2, y advances to next-oldest result.
REQ-037 At count=3, pulse rst between clock edges -> out_valid=0, count=0, y=0 without a clock edge; next accept (1,1) -> y=2.
